seq_shift_add_multiplier: RTL

- Multi-cycle signed shift-add multiplier datapath that sits directly downstream of the start/shot control stage.
- Consumes a single-cycle start pulse and two WORD_LENGTH-bit two's-complement operands.
- Performs one add/shift iteration per clock and presents a registered 2*WORD_LENGTH-bit product with a done level.
- Results drive the display/register stage that follows it.

---
 rtl/seq_shift_add_multiplier.sv | 71 +++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: signed sequential shift-add multiplier, one add/shift step per clock.
module seq_shift_add_multiplier #(
  parameter int WORD_LENGTH = 16,
  parameter int CNT_BITS = $clog2(WORD_LENGTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_BITS-1:0]        iteration
);
  localparam int W = WORD_LENGTH;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] mag_a, shreg, abs_a, abs_b;
  logic [W:0] acc, sum;
  logic [2*W-1:0] raw;
  logic neg, accept, last;
  assign abs_a = multiplicand[W-1] ? -multiplicand : multiplicand;
  assign abs_b = multiplier[W-1] ? -multiplier : multiplier;
  assign accept = start && !clear && (state == IDLE || state == DONE);
  assign last = iteration == CNT_BITS'(W - 1);
  assign sum = acc + {1'b0, mag_a & {W{shreg[0]}}};
  assign raw = {acc[W-1:0], shreg};
  assign busy = state == RUN || state == FIX;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = last ? FIX : RUN;
      FIX:     state_nx = DONE;
      DONE:    state_nx = accept ? RUN : DONE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // product is only written at FIX, so aborted runs never leak a partial result
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      product <= '0;
      iteration <= '0;
      mag_a <= '0;
      shreg <= '0;
      acc <= '0;
      neg <= 1'b0;
    end else if (clear) begin
      product <= '0;
      iteration <= '0;
    end else if (accept) begin
      mag_a <= abs_a;
      shreg <= abs_b;
      acc <= '0;
      neg <= multiplicand[W-1] ^ multiplier[W-1];
      iteration <= '0;
    end else if (state == RUN) begin
      acc <= {1'b0, sum[W:1]};
      shreg <= {sum[0], shreg[W-1:1]};
      iteration <= iteration + 1'b1;
    end else if (state == FIX) begin
      product <= neg ? -raw : raw;
    end
endmodule
